ult_echo_ranger: RTL and testbench

//  Measurement core for the HC-SR04-style ultrasonic ranger. Driven by the ultrasonic peripheral's

---
 rtl/ult_pkg.sv | 21 ++
 rtl/ult_echo_ranger_if.sv | 13 +
 rtl/ult_sync2.sv | 25 ++
 rtl/ult_echo_ranger.sv | 145 ++++++++++++++
 tb/tb_ult_echo_ranger.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ult_pkg.sv
// rtl/ult_pkg.sv - shared FSM encoding and acoustic constants for the ultrasonic ranger
package ult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_HOLDOFF
    } ult_state_t;

    localparam int SOUND_MPS = 343;

    // Round-trip echo time per mm: 2 mm of travel at SOUND_MPS, truncated to whole cycles.
    function automatic int calc_cyc_per_mm(input int clk_hz);
        return int'((64'(clk_hz) * 64'd2) / 64'(SOUND_MPS * 1000));
    endfunction

    localparam int CYC_PER_MM_DEFAULT = calc_cyc_per_mm(50_000_000);

endpackage

// File: rtl/ult_echo_ranger_if.sv
// rtl/ult_echo_ranger_if.sv - control, sensor and readback signals of the ranger core
interface ult_echo_ranger_if;
    logic        enable;
    logic        echo;
    logic        trigger;
    logic [15:0] value;
    logic        done;
    logic        busy;
    logic        timeout;

    modport master (output enable, echo, input trigger, value, done, busy, timeout);
    modport slave  (input enable, echo, output trigger, value, done, busy, timeout);
endinterface

// File: rtl/ult_sync2.sv
// rtl/ult_sync2.sv - 2-FF synchronizer with registered rise/fall strobes on the synced level
module ult_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= s1 & ~s2;
            fall <= ~s1 & s2;
        end
    end
endmodule

// File: rtl/ult_echo_ranger.sv
// rtl/ult_echo_ranger.sv - trigger generation, echo timing and mm conversion for an HC-SR04-style sensor
module ult_echo_ranger
    import ult_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TRIG_CYC    = 500,
    parameter int CYC_PER_MM  = calc_cyc_per_mm(CLK_HZ),
    parameter int MAX_MM      = 4000,
    parameter int WAIT_CYC    = 1_500_000,
    parameter int HOLDOFF_CYC = 3_000_000
) (
    input  logic              clk,
    input  logic              rst,
    ult_echo_ranger_if.slave  bus
);
    localparam int CNT_MAX = (WAIT_CYC > HOLDOFF_CYC)
                           ? ((WAIT_CYC > TRIG_CYC) ? WAIT_CYC : TRIG_CYC)
                           : ((HOLDOFF_CYC > TRIG_CYC) ? HOLDOFF_CYC : TRIG_CYC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int PRE_W = $clog2(CYC_PER_MM + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CYC_PER_MM - 1);
    localparam logic [15:0]      MM_SAT    = 16'(MAX_MM);

    ult_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] presc;
    logic [15:0]      mm_cnt;
    logic             trigger_q;
    logic [15:0]      value_q;
    logic             done_q;
    logic             busy_q;
    logic             timeout_q;
    logic             echo_rise;
    logic             echo_fall;

    ult_sync2 u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.echo),
        .rise (echo_rise),
        .fall (echo_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            presc     <= '0;
            mm_cnt    <= '0;
            trigger_q <= 1'b0;
            value_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state     <= ST_TRIG;
                        busy_q    <= 1'b1;
                        trigger_q <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        cnt       <= '0;
                    end
                end
                ST_TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state     <= ST_WAIT_ECHO;
                        trigger_q <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_ECHO: begin
                    // The rise cycle itself is the first echo-high cycle, so the prescaler starts at 1.
                    if (echo_rise) begin
                        state  <= ST_MEASURE;
                        presc  <= PRE_W'(1);
                        mm_cnt <= '0;
                    end else if (cnt == WAIT_LAST) begin
                        state     <= ST_HOLDOFF;
                        value_q   <= '0;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (mm_cnt == MM_SAT) begin
                        state     <= ST_HOLDOFF;
                        value_q   <= MM_SAT;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        cnt       <= '0;
                    end else if (echo_fall) begin
                        state   <= ST_HOLDOFF;
                        value_q <= mm_cnt;
                        done_q  <= 1'b1;
                        cnt     <= '0;
                    end else if (presc == PRE_LAST) begin
                        presc  <= '0;
                        mm_cnt <= mm_cnt + 16'd1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (bus.enable) begin
                            state     <= ST_TRIG;
                            trigger_q <= 1'b1;
                            done_q    <= 1'b0;
                            timeout_q <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                    trigger_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger = trigger_q;
    assign bus.value   = value_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_ult_echo_ranger.sv
// tb/tb_ult_echo_ranger.sv - directed table and sequence bench for ult_echo_ranger
module tb_ult_echo_ranger;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   trig_rises = 0;
    logic trig_prev = 1'b0;

    ult_echo_ranger_if bus ();

    ult_echo_ranger #(
        .TRIG_CYC    (5),
        .CYC_PER_MM  (10),
        .MAX_MM      (100),
        .WAIT_CYC    (200),
        .HOLDOFF_CYC (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.trigger && !trig_prev) trig_rises <= trig_rises + 1;
        trig_prev <= bus.trigger;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int delay;
        int width;
        int exp_value;
        int exp_timeout;
        int exp_lat;
    } vec_t;

    vec_t tv[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_trigger(input logic lvl, input int limit, output int n);
        n = 0;
        while (bus.trigger !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.trigger !== lvl) begin
            checks++;
            failures++;
            $display("FAIL wait_trigger actual=%0b expected=%0b after %0d cycles", bus.trigger, lvl, n);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=%0b expected=1 after %0d cycles", bus.done, n);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle busy actual=%0b expected=0 after %0d cycles", bus.busy, n);
        end
    endtask

    task automatic trigger_width(output int w);
        w = 0;
        while (bus.trigger === 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_echo(input int delay, input int width);
        repeat (delay) @(posedge clk);
        #1 bus.echo = 1'b1;
        repeat (width) @(posedge clk);
        #1 bus.echo = 1'b0;
    endtask

    initial begin
        int n;
        int w;
        int rises;

        tv[0] = '{20, 253, 25, 0, 0};
        tv[1] = '{0, 0, 0, 1, 200};
        tv[2] = '{5, 9, 0, 0, 0};
        tv[3] = '{5, 10, 1, 0, 0};
        tv[4] = '{150, 99, 9, 0, 0};
        tv[5] = '{30, 999, 99, 0, 0};
        tv[6] = '{197, 30, 3, 0, 0};
        tv[7] = '{10, 20, 2, 0, 0};

        bus.enable = 1'b0;
        bus.echo   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trigger", int'(bus.trigger), 0);
        check("rst_value", int'(bus.value), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_trigger", trig_rises, 0);
        check("idle_busy", int'(bus.busy), 0);

        bus.enable = 1'b1;
        wait_trigger(1'b1, 10, n);
        for (int i = 0; i < 8; i++) begin
            trigger_width(w);
            check($sformatf("v%0d_trig_width", i), w, 5);
            if (tv[i].width != 0) pulse_echo(tv[i].delay, tv[i].width);
            wait_done(3000, n);
            if (tv[i].exp_lat != 0) check($sformatf("v%0d_done_latency", i), n, tv[i].exp_lat);
            check($sformatf("v%0d_value", i), int'(bus.value), tv[i].exp_value);
            check($sformatf("v%0d_timeout", i), int'(bus.timeout), tv[i].exp_timeout);
            check($sformatf("v%0d_busy", i), int'(bus.busy), 1);
            if (i < 7) begin
                wait_trigger(1'b1, 100, n);
                check($sformatf("v%0d_holdoff", i), n, 50);
            end else begin
                bus.enable = 1'b0;
                wait_idle(100);
                check("table_end_done_held", int'(bus.done), 1);
            end
        end

        // Saturation: done must arrive while echo is still high.
        bus.enable = 1'b1;
        wait_trigger(1'b1, 10, n);
        bus.enable = 1'b0;
        wait_trigger(1'b0, 10, n);
        repeat (10) @(posedge clk);
        #1 bus.echo = 1'b1;
        wait_done(1500, n);
        check("sat_done_latency", n, 1004);
        check("sat_echo_still_high", int'(bus.echo), 1);
        check("sat_value", int'(bus.value), 100);
        check("sat_timeout", int'(bus.timeout), 1);
        repeat (1000) @(posedge clk);
        #1 bus.echo = 1'b0;
        wait_idle(100);

        // Enable dropped in WAIT_ECHO: measurement completes, then IDLE.
        bus.enable = 1'b1;
        wait_trigger(1'b1, 10, n);
        wait_trigger(1'b0, 10, n);
        bus.enable = 1'b0;
        pulse_echo(10, 50);
        wait_done(20, n);
        check("drop_value", int'(bus.value), 5);
        check("drop_timeout", int'(bus.timeout), 0);
        rises = trig_rises;
        repeat (80) @(negedge clk);
        check("drop_no_retrigger", trig_rises, rises);
        check("drop_busy", int'(bus.busy), 0);
        check("drop_done_held", int'(bus.done), 1);
        check("drop_value_held", int'(bus.value), 5);

        // Reset asserted mid-MEASURE clears outputs without waiting for a clock.
        bus.enable = 1'b1;
        wait_trigger(1'b1, 10, n);
        bus.enable = 1'b0;
        wait_trigger(1'b0, 10, n);
        bus.echo = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", int'(bus.busy), 1);
        check("pre_rst_value", int'(bus.value), 5);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_value", int'(bus.value), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_trigger", int'(bus.trigger), 0);
        check("mid_rst_timeout", int'(bus.timeout), 0);
        bus.echo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rises = trig_rises;
        repeat (30) @(negedge clk);
        check("post_rst_no_trigger", trig_rises, rises);
        check("post_rst_busy", int'(bus.busy), 0);

        // Echo already high during TRIG is ignored until a genuine rise in WAIT_ECHO.
        bus.enable = 1'b1;
        wait_trigger(1'b1, 10, n);
        bus.enable = 1'b0;
        bus.echo = 1'b1;
        wait_trigger(1'b0, 10, n);
        repeat (30) @(posedge clk);
        #1 bus.echo = 1'b0;
        pulse_echo(10, 77);
        wait_done(20, n);
        check("glitch_value", int'(bus.value), 7);
        check("glitch_timeout", int'(bus.timeout), 0);
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
